pc_fetch_gen: RTL and testbench

- Parametrised program-counter and fetch-request generator, the successor to the basic PC block.
- Sits between the decode/execute redirect logic and the instruction memory port.
- Adds over the basic PC:
  - valid/ready fetch handshake;
  - trap vectoring with fixed priority;
  - a halt/resume state machine;
  - redirect epoch tagging, so downstream stages can drop stale instructions;
  - configurable width and stride.

---
 rtl/pc_fetch_gen_if.sv | 26 ++
 rtl/pc_fetch_gen.sv | 190 +++++++++++++++++++
 tb/tb_pc_fetch_gen.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_gen_if.sv
// Fetch request bus between the PC generator (master) and instruction memory (slave).
// Handshake: a request transfers only on a cycle where fetch_valid && fetch_ready; the master may
// withdraw or replace a request while valid is high, and the slave must not assume address stability.
interface pc_fetch_gen_if #(
    parameter int ADDR_W  = 32,
    parameter int EPOCH_W = 2
);
    logic               fetch_valid;
    logic               fetch_ready;
    logic [ADDR_W-1:0]  fetch_addr;
    logic [EPOCH_W-1:0] fetch_epoch;

    modport master (
        output fetch_valid,
        output fetch_addr,
        output fetch_epoch,
        input  fetch_ready
    );

    modport slave (
        input  fetch_valid,
        input  fetch_addr,
        input  fetch_epoch,
        output fetch_ready
    );
endinterface

// File: rtl/pc_fetch_gen.sv
// Program counter and fetch-request generator with trap/redirect priority, halt/resume and epochs.
// Optional return-address stack is enabled by defining PC_RAS_EN.
module pc_fetch_gen #(
    parameter int                ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
    parameter int                INSTR_BYTES = 4,
    parameter int                EPOCH_W     = 2,
    parameter int                RAS_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    pc_fetch_gen_if.master    fetch,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              trap,
    input  logic [ADDR_W-1:0] trap_vec,
    input  logic              halt_req,
    input  logic              resume,
    output logic              halted,
    output logic              misalign,
`ifdef PC_RAS_EN
    input  logic              ras_push,
    input  logic              ras_pop,
    output logic              ras_empty,
`endif
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_e;

    localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(INSTR_BYTES);
    localparam logic [ADDR_W-1:0] LOW_MASK = STRIDE - ADDR_W'(1);

    state_e             state_q;
    logic               boot_q;
    logic [ADDR_W-1:0]  pc_q;
    logic [EPOCH_W-1:0] epoch_q;
    logic               valid_q;
    logic               halted_q;
    logic               misalign_q;

    logic [ADDR_W-1:0]  pc_inc;
    logic [EPOCH_W-1:0] epoch_inc;
    logic [ADDR_W-1:0]  redir_tgt;
    logic [ADDR_W-1:0]  trap_tgt;
    logic               redir_mis;
    logic               trap_mis;
    logic               ras_take;
    logic [ADDR_W-1:0]  ras_top;

    assign pc_inc    = pc_q + STRIDE;
    assign epoch_inc = epoch_q + EPOCH_W'(1);
    assign redir_tgt = redirect_pc & ~LOW_MASK;
    assign trap_tgt  = trap_vec & ~LOW_MASK;
    assign redir_mis = |(redirect_pc & LOW_MASK);
    assign trap_mis  = |(trap_vec & LOW_MASK);

    assign fetch.fetch_valid = valid_q;
    assign fetch.fetch_addr  = pc_q;
    assign fetch.fetch_epoch = epoch_q;
    assign halted            = halted_q;
    assign misalign          = misalign_q;
    assign dbg_state_o       = state_q;

    // BOOT spans two cycles so the first request appears two cycles after the last reset edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            boot_q     <= 1'b0;
            pc_q       <= RESET_VEC;
            epoch_q    <= '0;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= 1'b0;
            case (state_q)
                BOOT: begin
                    pc_q   <= RESET_VEC;
                    boot_q <= 1'b1;
                    if (boot_q) begin
                        state_q <= RUN;
                        valid_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (trap) begin
                        pc_q       <= trap_tgt;
                        epoch_q    <= epoch_inc;
                        misalign_q <= trap_mis;
                    end else if (redirect) begin
                        pc_q       <= redir_tgt;
                        epoch_q    <= epoch_inc;
                        misalign_q <= redir_mis;
                        if (halt_req) begin
                            state_q  <= HALTED;
                            valid_q  <= 1'b0;
                            halted_q <= 1'b1;
                        end
                    end else if (ras_take) begin
                        pc_q    <= ras_top;
                        epoch_q <= epoch_inc;
                    end else begin
                        // A request accepted in the halting cycle still advances the pc.
                        if (fetch.fetch_ready) begin
                            pc_q <= pc_inc;
                        end
                        if (halt_req) begin
                            state_q  <= HALTED;
                            valid_q  <= 1'b0;
                            halted_q <= 1'b1;
                        end
                    end
                end
                HALTED: begin
                    if (trap) begin
                        pc_q       <= trap_tgt;
                        epoch_q    <= epoch_inc;
                        misalign_q <= trap_mis;
                        state_q    <= RUN;
                        valid_q    <= 1'b1;
                        halted_q   <= 1'b0;
                    end else if (redirect) begin
                        pc_q       <= redir_tgt;
                        epoch_q    <= epoch_inc;
                        misalign_q <= redir_mis;
                    end else if (resume) begin
                        state_q  <= RUN;
                        valid_q  <= 1'b1;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= BOOT;
                    boot_q   <= 1'b0;
                    valid_q  <= 1'b0;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef PC_RAS_EN
    localparam int               PTR_W    = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int               CNT_W    = $clog2(RAS_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] ras_mem_q [RAS_DEPTH];
    logic [PTR_W-1:0]  ras_sp_q;
    logic [PTR_W-1:0]  ras_sp_dec;
    logic [PTR_W-1:0]  ras_sp_inc;
    logic [CNT_W-1:0]  ras_cnt_q;
    logic              ras_put;

    assign ras_sp_dec = (ras_sp_q == '0) ? PTR_LAST : ras_sp_q - PTR_W'(1);
    assign ras_sp_inc = (ras_sp_q == PTR_LAST) ? '0 : ras_sp_q + PTR_W'(1);
    assign ras_top    = ras_mem_q[ras_sp_dec];
    assign ras_empty  = (ras_cnt_q == '0);
    assign ras_take   = (state_q == RUN) && ras_pop && !trap && !redirect && !ras_empty;
    assign ras_put    = valid_q && fetch.fetch_ready && ras_push;

    // Circular buffer: a push onto a full stack silently overwrites the oldest entry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ras_sp_q  <= '0;
            ras_cnt_q <= '0;
        end else if (ras_take && ras_put) begin
            ras_mem_q[ras_sp_dec] <= pc_inc;
        end else if (ras_take) begin
            ras_sp_q  <= ras_sp_dec;
            ras_cnt_q <= ras_cnt_q - CNT_W'(1);
        end else if (ras_put) begin
            ras_mem_q[ras_sp_q] <= pc_inc;
            ras_sp_q            <= ras_sp_inc;
            if (ras_cnt_q != CNT_FULL) begin
                ras_cnt_q <= ras_cnt_q + CNT_W'(1);
            end
        end
    end
`else
    assign ras_take = 1'b0;
    assign ras_top  = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Randomized + directed bench for pc_fetch_gen against a behavioural model of the fetch rules.
module tb_pc_fetch_gen;

    localparam int ADDR_W      = 32;
    localparam int EPOCH_W     = 2;
    localparam int INSTR_BYTES = 4;
    localparam int RAS_DEPTH   = 4;
    localparam longint unsigned AMASK   = (64'd1 << ADDR_W) - 64'd1;
    localparam longint unsigned RST_VEC = 64'd0;

    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              trap;
    logic [ADDR_W-1:0] trap_vec;
    logic              halt_req;
    logic              resume;
    logic              halted;
    logic              misalign;
    logic [1:0]        dbg_state;
`ifdef PC_RAS_EN
    logic              ras_push;
    logic              ras_pop;
    logic              ras_empty;
`endif

    pc_fetch_gen_if #(.ADDR_W(ADDR_W), .EPOCH_W(EPOCH_W)) fetch_if ();

    pc_fetch_gen #(
        .ADDR_W     (ADDR_W),
        .RESET_VEC  (RST_VEC[ADDR_W-1:0]),
        .INSTR_BYTES(INSTR_BYTES),
        .EPOCH_W    (EPOCH_W),
        .RAS_DEPTH  (RAS_DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fetch      (fetch_if),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .trap       (trap),
        .trap_vec   (trap_vec),
        .halt_req   (halt_req),
        .resume     (resume),
        .halted     (halted),
        .misalign   (misalign),
`ifdef PC_RAS_EN
        .ras_push   (ras_push),
        .ras_pop    (ras_pop),
        .ras_empty  (ras_empty),
`endif
        .dbg_state_o(dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [ADDR_W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    int              m_state;
    int              m_boot_left;
    longint unsigned m_pc;
    int              m_epoch;
    bit              m_mis;
    bit              m_acc;
    longint unsigned m_ras[$];

    function automatic longint unsigned align_t(input longint unsigned x);
        return (x / INSTR_BYTES) * INSTR_BYTES;
    endfunction

    task automatic take_target(input longint unsigned x);
        m_pc    = align_t(x);
        m_mis   = (x % INSTR_BYTES) != 0;
        m_epoch = (m_epoch + 1) % (1 << EPOCH_W);
    endtask

    task automatic model_step();
        longint unsigned nxt;
        m_mis = 1'b0;
        m_acc = 1'b0;
        if (!rst_n) begin
            m_state     = M_BOOT;
            m_boot_left = 2;
            m_pc        = RST_VEC;
            m_epoch     = 0;
            m_ras.delete();
            return;
        end
        nxt = (m_pc + INSTR_BYTES) & AMASK;
        case (m_state)
            M_BOOT: begin
                m_boot_left--;
                if (m_boot_left == 0) m_state = M_RUN;
            end
            M_RUN: begin
                m_acc = fetch_if.fetch_ready;
                if (m_acc) exp_q.push_back(m_pc[ADDR_W-1:0]);
                if (trap) take_target(trap_vec);
                else if (redirect) begin
                    take_target(redirect_pc);
                    if (halt_req) m_state = M_HALT;
                end
`ifdef PC_RAS_EN
                else if (ras_pop && m_ras.size() > 0) begin
                    m_pc    = m_ras.pop_back();
                    m_epoch = (m_epoch + 1) % (1 << EPOCH_W);
                end
`endif
                else begin
                    if (fetch_if.fetch_ready) m_pc = nxt;
                    if (halt_req) m_state = M_HALT;
                end
`ifdef PC_RAS_EN
                if (m_acc && ras_push) begin
                    m_ras.push_back(nxt);
                    if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
                end
`endif
            end
            default: begin
                if (trap) begin
                    take_target(trap_vec);
                    m_state = M_RUN;
                end else if (redirect) take_target(redirect_pc);
                else if (resume) m_state = M_RUN;
            end
        endcase
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        redirect    = 1'b0;
        trap        = 1'b0;
        halt_req    = 1'b0;
        resume      = 1'b0;
        redirect_pc = '0;
        trap_vec    = '0;
`ifdef PC_RAS_EN
        ras_push = 1'b0;
        ras_pop  = 1'b0;
`endif
    endtask

    task automatic drive_redirect(input logic [ADDR_W-1:0] a);
        redirect    = 1'b1;
        redirect_pc = a;
    endtask

    function automatic logic [ADDR_W-1:0] rand_target();
        logic [ADDR_W-1:0] t;
        if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFF0 | ADDR_W'($urandom_range(0, 15));
        else t = ADDR_W'($urandom());
        return t;
    endfunction

    // One clock: note the DUT handshake, advance model, compare on the falling edge.
    task automatic cycle();
        logic              dut_acc;
        logic [ADDR_W-1:0] dut_addr;
        logic [ADDR_W-1:0] e;
        dut_acc  = fetch_if.fetch_valid && fetch_if.fetch_ready && rst_n;
        dut_addr = fetch_if.fetch_addr;
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (dut_acc || m_acc) check("accept", dut_acc, m_acc);
        if (m_acc) begin
            e = exp_q.pop_front();
            if (dut_acc) check("acc_addr", dut_addr, e);
        end
        check("valid", fetch_if.fetch_valid, m_state == M_RUN);
        check("halted", halted, m_state == M_HALT);
        check("addr", fetch_if.fetch_addr, m_pc);
        check("epoch", fetch_if.fetch_epoch, m_epoch);
        check("misalign", misalign, m_mis);
`ifdef PC_RAS_EN
        check("ras_empty", ras_empty, m_ras.size() == 0);
`endif
    endtask

    // ---------------- stimulus ----------------
    initial begin
        drive_idle();
        fetch_if.fetch_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) cycle();

        rst_n = 1'b1;
        cycle();
        check("t1_boot_valid", fetch_if.fetch_valid, 0);
        cycle();
        check("t1_first_valid", fetch_if.fetch_valid, 1);
        check("t1_addr0", fetch_if.fetch_addr, 32'h0);
        cycle();
        check("t1_addr4", fetch_if.fetch_addr, 32'h4);
        cycle();
        check("t1_addr8", fetch_if.fetch_addr, 32'h8);
        check("t1_epoch", fetch_if.fetch_epoch, 0);

        repeat (2) cycle();
        check("t2_at10", fetch_if.fetch_addr, 32'h10);
        fetch_if.fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("t2_stall", fetch_if.fetch_addr, 32'h10);
        end
        fetch_if.fetch_ready = 1'b1;
        cycle();
        check("t2_next", fetch_if.fetch_addr, 32'h14);

        fetch_if.fetch_ready = 1'b0;
        drive_redirect(32'h103);
        cycle();
        check("t3_addr", fetch_if.fetch_addr, 32'h100);
        check("t3_epoch", fetch_if.fetch_epoch, 1);
        check("t3_mis", misalign, 1);
        drive_idle();
        cycle();
        check("t3_mis_clear", misalign, 0);

        trap = 1'b1;
        trap_vec = 32'h80;
        drive_redirect(32'h200);
        cycle();
        check("t4_addr", fetch_if.fetch_addr, 32'h80);
        check("t4_epoch", fetch_if.fetch_epoch, 2);
        drive_idle();

        halt_req = 1'b1;
        cycle();
        check("t5_valid", fetch_if.fetch_valid, 0);
        check("t5_halted", halted, 1);
        drive_idle();
        drive_redirect(32'h40);
        cycle();
        check("t5_still_halted", halted, 1);
        drive_idle();
        resume = 1'b1;
        cycle();
        check("t5_resume_valid", fetch_if.fetch_valid, 1);
        check("t5_resume_addr", fetch_if.fetch_addr, 32'h40);
        drive_idle();
        drive_redirect(32'hFFFF_FFFC);
        cycle();
        check("t5_epoch_wrap", fetch_if.fetch_epoch, 0);
        drive_idle();
        fetch_if.fetch_ready = 1'b1;
        cycle();
        check("t5_pc_wrap", fetch_if.fetch_addr, 32'h0);

`ifdef PC_RAS_EN
        fetch_if.fetch_ready = 1'b0;
        drive_redirect(32'h20);
        cycle();
        drive_idle();
        fetch_if.fetch_ready = 1'b1;
        ras_push = 1'b1;
        cycle();
        drive_idle();
        fetch_if.fetch_ready = 1'b0;
        drive_redirect(32'h300);
        cycle();
        drive_idle();
        ras_pop = 1'b1;
        cycle();
        check("t6_pop_addr", fetch_if.fetch_addr, 32'h24);
        cycle();
        check("t6_pop_ignored", fetch_if.fetch_addr, 32'h24);
        check("t6_empty", ras_empty, 1);
        drive_idle();
`endif

        for (int i = 0; i < 800; i++) begin
            rst_n                = ($urandom_range(0, 199) != 0);
            fetch_if.fetch_ready = ($urandom_range(0, 3) != 0);
            redirect             = ($urandom_range(0, 9) == 0);
            redirect_pc          = rand_target();
            trap                 = ($urandom_range(0, 19) == 0);
            trap_vec             = rand_target();
            halt_req             = ($urandom_range(0, 14) == 0);
            resume               = ($urandom_range(0, 3) == 0);
`ifdef PC_RAS_EN
            ras_push = ($urandom_range(0, 2) == 0);
            ras_pop  = ($urandom_range(0, 4) == 0);
`endif
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
